uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive front end for the RSA datapath. It recovers 8N1 bytes from the asynchronous `rx` pin and presents each byte as a single-cycle `rx_valid` / `rx_byte` strobe. That strobe directly feeds the `rx_valid` and `rx_byte` inputs of `serial_to_parallel`, which assembles the operands for `mon_exp`. Framing violations are flagged on `rx_error` and never forwarded as data.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per UART bit (12 MHz / 115200). Minimum legal value is 4.
- `CNT_BITS`, default 7: counter width. Must satisfy 2^CNT_BITS > CLKS_PER_BIT.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rx`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `rx_valid`  out  1  one-cycle strobe; `rx_byte` holds a good byte.
- `rx_byte`  out  8  last correctly framed byte; LSB received first.
- `rx_error`  out  1  one-cycle strobe on framing error (stop bit sampled 0).
- `is_receiving`  out  1  high in every state except IDLE.

## Operation
- **Synchronizer**
  - `rx` passes through 2 flops to produce `rx_s`.
  - Both flops reset to 1, so the line reads as idle out of reset.
- **State machine:** IDLE, START, DATA, STOP, WAIT_IDLE. Registers: `cnt` (CNT_BITS), `bit_idx` (3 bits), `shift` (8 bits).
- **IDLE**
  - On `rx_s`==0: go to START with `cnt`=0.
- **START**
  - `cnt` increments every cycle.
  - At `cnt`==CLKS_PER_BIT/2−1 (integer division), sample `rx_s`.
  - If 0: go to DATA with `cnt`=0, `bit_idx`=0.
  - If 1 (glitch / false start): return to IDLE with no output.
- **DATA**
  - At `cnt`==CLKS_PER_BIT−1, sample `rx_s` into `shift[bit_idx]` (LSB first), clear `cnt`, increment `bit_idx`.
  - After the sample with `bit_idx`==7, go to STOP.
  - Otherwise `cnt` increments.
- **STOP**
  - At `cnt`==CLKS_PER_BIT−1, sample `rx_s`.
  - If 1: `rx_byte`<=`shift`, `rx_valid`<=1, go to IDLE.
  - If 0: `rx_error`<=1, go to WAIT_IDLE.
  - `rx_byte` is not updated on error.
- **WAIT_IDLE**
  - Stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as a stream of 0x00 bytes.
- **Output rules**
  - `rx_valid` and `rx_error` are registered and high for exactly one cycle. They are never high together.
  - `rx_byte` holds its value between strobes.
  - There is no backpressure. The downstream stage must accept every strobe; `serial_to_parallel` does so unconditionally.

## Timing
- **Reset values:** `rx_valid`=0, `rx_error`=0, `rx_byte`=8'h00, `is_receiving`=0, state=IDLE, `cnt`=0, `bit_idx`=0, `shift`=0, sync flops=1.
- **Reset mid-frame:** all registers return to the reset values immediately; no strobe is produced for the partial byte.
- **Reception timing:** let T0 be the first rising edge at which `rx_s`==0 in IDLE (2–3 cycles after the pin falls).
  - Start is confirmed at T0+CLKS_PER_BIT/2.
  - Data bit k is sampled at T0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT.
  - The stop bit is sampled at T0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `rx_valid`/`rx_error` is visible in the cycle after that edge.
- **Back-to-back frames:** the state returns to IDLE at mid stop bit, about CLKS_PER_BIT/2 cycles before the next start edge can arrive. Consecutive frames with no idle gap must all be received.
- **False start:** a low pulse shorter than CLKS_PER_BIT/2 − 2 cycles never leaves START → IDLE. `is_receiving` may pulse, but no strobe is produced.
- **Bit-rate tolerance:** sampling at mid-bit tolerates ±4% bit-rate mismatch over a frame.

## Test plan
All scenarios run with CLKS_PER_BIT=16, and the bench drives `rx` bit-accurately.
- **Single byte:** send 0xAA → exactly one `rx_valid` pulse, `rx_byte`=0xAA, `rx_error` never asserted, `is_receiving` back to 0 afterward.
- **Back-to-back burst:** send 0xAA, 0xBB, 0xCC, 0xDD with zero idle gap → four `rx_valid` pulses, `rx_byte` 0xAA, 0xBB, 0xCC, 0xDD in order.
- **Glitch:** `rx` low for 3 cycles, then high → no `rx_valid`/`rx_error`, state returns to IDLE. A following 0x5A is then received correctly.
- **Framing error:** send 0x3C with stop bit 0, hold `rx` low 40 cycles, then release high, then send 0x81. Required response:
  - one `rx_error` pulse and no `rx_valid`;
  - `rx_byte` stays at its previous value;
  - no further strobes while `rx` is held low;
  - 0x81 then received with a single `rx_valid`.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xF0 → all outputs 0 at once, no strobe for 0xF0. A subsequent 0x0F is received correctly.
- **Extreme patterns:** send 0x00, then 0xFF → two `rx_valid` pulses with `rx_byte` 0x00 then 0xFF; `rx_error` stays 0 throughout.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, and
// single-cycle rx_valid / rx_error strobes with rx_byte holding the last good byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int CNT_BITS     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_error,
  output logic       is_receiving
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge on rx_s
  // START     | counting to mid start bit to confirm it is still low
  // DATA      | sampling 8 data bits at mid-bit, LSB first
  // STOP      | sampling the stop bit at mid-bit
  // WAIT_IDLE | framing error seen, waiting for the line to return high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam logic [CNT_BITS-1:0] HALF_M1 = CNT_BITS'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_BITS-1:0] FULL_M1 = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic                rx_meta_q, rx_s_q;
  logic [2:0]          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          byte_q, byte_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;

  // Synchronizer flops reset high so the line reads idle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
    end
  end

  assign rx_valid     = valid_q;
  assign rx_error     = error_q;
  assign rx_byte      = byte_q;
  assign is_receiving = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; a negedge monitor logs
// every strobe so each scenario task can check counts and received bytes.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       is_receiving;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .CNT_BITS(5)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .rx_error(rx_error), .is_receiving(is_receiving)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) got_q.push_back(rx_byte);
    if (rx_error) err_cnt++;
    if (rx_valid && rx_error) both_cnt++;
  end

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(stop_bit, CPB);
  endtask

  task automatic clear_log();
    got_q.delete();
    err_cnt  = 0;
    both_cnt = 0;
  endtask

  task automatic test_reset();
    total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", rx_valid); else pass_cnt++;
    total_cnt++; if (rx_error !== 1'b0) $display("FAIL reset_error: got %b exp 0", rx_error); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h00) $display("FAIL reset_byte: got %h exp 00", rx_byte); else pass_cnt++;
    total_cnt++; if (is_receiving !== 1'b0) $display("FAIL reset_busy: got %b exp 0", is_receiving); else pass_cnt++;
  endtask

  task automatic test_single();
    clear_log();
    drive_bit(1'b0, CPB);
    drive_bit(1'b0, 4);
    total_cnt++; if (is_receiving !== 1'b1) $display("FAIL single_busy_mid: got %b exp 1", is_receiving); else pass_cnt++;
    drive_bit(1'b0, CPB - 4);
    for (int i = 1; i < 8; i++) drive_bit(i[0], CPB);
    drive_bit(1'b1, CPB);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL single_count: got %0d exp 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'hAA) $display("FAIL single_byte: got %h exp aa", rx_byte); else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL single_err: got %0d exp 0", err_cnt); else pass_cnt++;
    total_cnt++; if (is_receiving !== 1'b0) $display("FAIL single_busy_end: got %b exp 0", is_receiving); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[4];
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    for (int i = 0; i < 4; i++) send_byte(exp_b[i], 1'b1);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 4) $display("FAIL b2b_count: got %0d exp 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (got_q.size() <= i) $display("FAIL b2b_byte%0d: got none exp %h", i, exp_b[i]);
      else if (got_q[i] !== exp_b[i]) $display("FAIL b2b_byte%0d: got %h exp %h", i, got_q[i], exp_b[i]);
      else pass_cnt++;
    end
    total_cnt++; if (err_cnt !== 0) $display("FAIL b2b_err: got %0d exp 0", err_cnt); else pass_cnt++;
  endtask

  task automatic test_glitch();
    clear_log();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 30);
    total_cnt++; if (got_q.size() !== 0) $display("FAIL glitch_valid: got %0d exp 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL glitch_err: got %0d exp 0", err_cnt); else pass_cnt++;
    total_cnt++; if (is_receiving !== 1'b0) $display("FAIL glitch_busy: got %b exp 0", is_receiving); else pass_cnt++;
    send_byte(8'h5A, 1'b1);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL glitch_next_count: got %0d exp 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h5A) $display("FAIL glitch_next_byte: got %h exp 5a", rx_byte); else pass_cnt++;
  endtask

  task automatic test_framing();
    clear_log();
    send_byte(8'h3C, 1'b0);
    drive_bit(1'b0, 40);
    total_cnt++; if (err_cnt !== 1) $display("FAIL frame_err_count: got %0d exp 1", err_cnt); else pass_cnt++;
    total_cnt++; if (got_q.size() !== 0) $display("FAIL frame_valid: got %0d exp 0", got_q.size()); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h5A) $display("FAIL frame_byte_hold: got %h exp 5a", rx_byte); else pass_cnt++;
    total_cnt++; if (is_receiving !== 1'b1) $display("FAIL frame_wait_busy: got %b exp 1", is_receiving); else pass_cnt++;
    drive_bit(1'b1, 20);
    total_cnt++; if (is_receiving !== 1'b0) $display("FAIL frame_release_busy: got %b exp 0", is_receiving); else pass_cnt++;
    send_byte(8'h81, 1'b1);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL frame_next_count: got %0d exp 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h81) $display("FAIL frame_next_byte: got %h exp 81", rx_byte); else pass_cnt++;
    total_cnt++; if (err_cnt !== 1) $display("FAIL frame_err_final: got %0d exp 1", err_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clear_log();
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, CPB);
    drive_bit(1'b1, CPB / 2);
    total_cnt++; if (is_receiving !== 1'b1) $display("FAIL rstmid_busy_before: got %b exp 1", is_receiving); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (is_receiving !== 1'b0) $display("FAIL rstmid_busy: got %b exp 0", is_receiving); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h00) $display("FAIL rstmid_byte: got %h exp 00", rx_byte); else pass_cnt++;
    total_cnt++; if (rx_valid !== 1'b0 || rx_error !== 1'b0) $display("FAIL rstmid_strobes: got %b%b exp 00", rx_valid, rx_error); else pass_cnt++;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    drive_bit(1'b1, 2 * CPB);
    total_cnt++; if (got_q.size() !== 0) $display("FAIL rstmid_no_strobe: got %0d exp 0", got_q.size()); else pass_cnt++;
    send_byte(8'h0F, 1'b1);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 1) $display("FAIL rstmid_next_count: got %0d exp 1", got_q.size()); else pass_cnt++;
    total_cnt++; if (rx_byte !== 8'h0F) $display("FAIL rstmid_next_byte: got %h exp 0f", rx_byte); else pass_cnt++;
  endtask

  task automatic test_extreme();
    clear_log();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    drive_bit(1'b1, 20);
    total_cnt++; if (got_q.size() !== 2) $display("FAIL ext_count: got %0d exp 2", got_q.size()); else pass_cnt++;
    total_cnt++;
    if (got_q.size() < 1) $display("FAIL ext_byte0: got none exp 00");
    else if (got_q[0] !== 8'h00) $display("FAIL ext_byte0: got %h exp 00", got_q[0]);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() < 2) $display("FAIL ext_byte1: got none exp ff");
    else if (got_q[1] !== 8'hFF) $display("FAIL ext_byte1: got %h exp ff", got_q[1]);
    else pass_cnt++;
    total_cnt++; if (err_cnt !== 0) $display("FAIL ext_err: got %0d exp 0", err_cnt); else pass_cnt++;
    total_cnt++; if (both_cnt !== 0) $display("FAIL ext_both_strobes: got %0d exp 0", both_cnt); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    drive_bit(1'b1, 5);
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_extreme();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
